// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage issue controller.
package hazard_pkg;

    localparam int REG_W      = 5;
    localparam int NUM_REGS   = 32;
    localparam int INFLIGHT_W = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1
    } state_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// Per-register busy bits: one set port, one clear port, two source read ports and a
// destination (WAW) read port. Register 0 is hardwired clear.
module hazard_ctrl_scoreboard
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_idx,
    input  logic [REG_W-1:0] rd_a_idx,
    input  logic [REG_W-1:0] rd_b_idx,
    input  logic [REG_W-1:0] rd_w_idx,
    output logic             rd_a_hit,
    output logic             rd_b_hit,
    output logic             rd_w_hit
);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_next;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    always_comb begin
        set_mask = set_en ? reg_onehot(set_idx) : '0;
        clr_mask = clr_en ? reg_onehot(clr_idx) : '0;
        // Set is applied after clear so a same-cycle set/clear on one register leaves it busy.
        pending_next    = (pending & ~clr_mask) | set_mask;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign rd_a_hit = pending[rd_a_idx];
    assign rd_b_hit = pending[rd_b_idx];
    assign rd_w_hit = pending[rd_w_idx];

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage issue controller: scoreboard hazards, in-flight bound and serial drain.
// Optional result forwarding is enabled with `define HAZARD_CTRL_FWD_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_rs1_used_i,
    input  logic             id_rs2_used_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             id_rf_we_i,
    input  logic             id_is_load_i,
    input  logic             id_is_serial_i,
    input  logic             ex_branch_taken_i,
`ifdef HAZARD_CTRL_FWD_EN
    input  logic             ex_res_valid_i,
    input  logic [REG_W-1:0] ex_rd_i,
`endif
    input  logic             wb_valid_i,
    input  logic [REG_W-1:0] wb_rd_i,
    input  logic             wb_rf_we_i,
    output logic             issue_o,
    output logic             stall_o,
    output logic             flush_o,
    output logic             busy_o
);

    state_e                  state;
    logic [INFLIGHT_W-1:0]   inflight;
    logic [INFLIGHT_W-1:0]   inflight_next;
    logic                    retire;
    logic                    full;
    logic                    serial_block;
    logic                    hazard;
    logic                    pend_set;
    logic                    pend_rs1;
    logic                    pend_rs2;
    logic                    pend_rd;

`ifdef HAZARD_CTRL_FWD_EN
    logic                    fwd_set;
    logic                    fwd_rs1;
    logic                    fwd_rs2;
    logic                    fwd_rd;

    // ALU results are bypassed from EX, so they only need a one-cycle shadow bit.
    assign pend_set = issue_o & id_rf_we_i & id_is_load_i;
    assign fwd_set  = issue_o & id_rf_we_i & ~id_is_load_i;

    hazard_ctrl_scoreboard u_fwd (
        .clk      (clk_i),
        .rst      (rst_i),
        .set_en   (fwd_set),
        .set_idx  (id_rd_i),
        .clr_en   (ex_res_valid_i),
        .clr_idx  (ex_rd_i),
        .rd_a_idx (id_rs1_i),
        .rd_b_idx (id_rs2_i),
        .rd_w_idx (id_rd_i),
        .rd_a_hit (fwd_rs1),
        .rd_b_hit (fwd_rs2),
        .rd_w_hit (fwd_rd)
    );

    assign hazard = (id_rs1_used_i & (pend_rs1 | fwd_rs1))
                  | (id_rs2_used_i & (pend_rs2 | fwd_rs2))
                  | (id_rf_we_i    & (pend_rd  | fwd_rd));
`else
    logic                    unused_load;

    assign unused_load = id_is_load_i;
    assign pend_set    = issue_o & id_rf_we_i;

    assign hazard = (id_rs1_used_i & pend_rs1)
                  | (id_rs2_used_i & pend_rs2)
                  | (id_rf_we_i    & pend_rd);
`endif

    hazard_ctrl_scoreboard u_pend (
        .clk      (clk_i),
        .rst      (rst_i),
        .set_en   (pend_set),
        .set_idx  (id_rd_i),
        .clr_en   (wb_valid_i & wb_rf_we_i),
        .clr_idx  (wb_rd_i),
        .rd_a_idx (id_rs1_i),
        .rd_b_idx (id_rs2_i),
        .rd_w_idx (id_rd_i),
        .rd_a_hit (pend_rs1),
        .rd_b_hit (pend_rs2),
        .rd_w_hit (pend_rd)
    );

    assign full         = (inflight == INFLIGHT_W'(MAX_INFLIGHT));
    assign serial_block = id_is_serial_i & (inflight != '0);

    // Outputs are forced low while reset is held so downstream stages see a quiet ID.
    assign issue_o = ~rst_i & id_valid_i & ~ex_branch_taken_i & ~hazard & ~full
                   & (state == ST_RUN) & ~serial_block;
    assign stall_o = ~rst_i & id_valid_i & ~issue_o & ~ex_branch_taken_i;
    assign flush_o = ~rst_i & ex_branch_taken_i;
    assign busy_o  = ~rst_i & ((state != ST_RUN) | (inflight != '0));

    // A retire with nothing in flight is spurious and must not underflow the count.
    assign retire = wb_valid_i & (inflight != '0);

    always_comb begin
        inflight_next = inflight;
        case ({issue_o, retire})
            2'b10:   inflight_next = inflight + 1'b1;
            2'b01:   inflight_next = inflight - 1'b1;
            default: inflight_next = inflight;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= ST_RUN;
            inflight <= '0;
        end else begin
            inflight <= inflight_next;
            case (state)
                ST_RUN: begin
                    if (issue_o & id_is_serial_i) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The serial instruction is the only one in flight, so empty means it retired.
                    if (inflight_next == '0) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random traffic
// against an in-order queue model of the issued-but-not-retired instructions.
module tb_hazard_ctrl;

    localparam int MAX = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, we, ld, ser, br;
    logic       wbv, wbwe;
    logic [4:0] wbrd;
    logic       issue, stall, flush, busy;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int rd;
        bit we;
        bit ser;
    } ent_t;

    ent_t q[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.MAX_INFLIGHT(MAX)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .id_valid_i        (id_valid),
        .id_rs1_i          (rs1),
        .id_rs2_i          (rs2),
        .id_rs1_used_i     (u1),
        .id_rs2_used_i     (u2),
        .id_rd_i           (rd),
        .id_rf_we_i        (we),
        .id_is_load_i      (ld),
        .id_is_serial_i    (ser),
        .ex_branch_taken_i (br),
        .wb_valid_i        (wbv),
        .wb_rd_i           (wbrd),
        .wb_rf_we_i        (wbwe),
        .issue_o           (issue),
        .stall_o           (stall),
        .flush_o           (flush),
        .busy_o            (busy)
    );

    // A register is busy iff some in-flight instruction will write it.
    function automatic bit pend(int r);
        if (r == 0) return 1'b0;
        foreach (q[i]) if (q[i].we && q[i].rd == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit draining();
        foreach (q[i]) if (q[i].ser) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input string tag, input int ei = -1, input int es = -1, input int eb = -1);
        bit hz, xi, xs, xf, xb;
        @(negedge clk);
        hz = (u1 && pend(rs1)) || (u2 && pend(rs2)) || (we && pend(rd));
        xi = !rst && id_valid && !br && !hz && (q.size() < MAX) && !draining()
             && !(ser && q.size() != 0);
        xs = !rst && id_valid && !xi && !br;
        xf = !rst && br;
        xb = !rst && (q.size() != 0);
        chk({tag, ".issue"}, issue, xi);
        chk({tag, ".stall"}, stall, xs);
        chk({tag, ".flush"}, flush, xf);
        chk({tag, ".busy"},  busy,  xb);
        if (ei >= 0) chk({tag, ".issue_dir"}, issue, ei[0]);
        if (es >= 0) chk({tag, ".stall_dir"}, stall, es[0]);
        if (eb >= 0) chk({tag, ".busy_dir"},  busy,  eb[0]);
        @(posedge clk);
        if (rst) begin
            q.delete();
        end else begin
            if (wbv && q.size() != 0) void'(q.pop_front());
            if (xi) q.push_back('{int'(rd), we, ser});
        end
        #1;
    endtask

    task automatic id_set(input bit v, input int a, input bit ua, input int b, input bit ub,
                          input int d, input bit w, input bit s);
        id_valid = v;
        rs1 = 5'(a); u1 = ua;
        rs2 = 5'(b); u2 = ub;
        rd  = 5'(d); we = w;
        ser = s;     ld = 1'b0;
    endtask

    task automatic wb_none();
        wbv = 1'b0; wbrd = '0; wbwe = 1'b0;
    endtask

    task automatic wb_front();
        if (q.size() != 0) begin
            wbv = 1'b1; wbrd = 5'(q[0].rd); wbwe = q[0].we;
        end else begin
            wb_none();
        end
    endtask

    task automatic drain_all(input string tag);
        int guard;
        guard = 0;
        id_set(0, 0, 0, 0, 0, 0, 0, 0);
        br = 1'b0;
        while (q.size() != 0 && guard < 50) begin
            wb_front();
            tick(tag);
            guard++;
        end
        wb_none();
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL %s drain_timeout observed=%0d entries required=0", tag, q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; br = 1'b0;
        id_set(1, 0, 0, 0, 0, 5, 1, 0);
        wb_none();

        // Reset held two cycles with a valid instruction in ID.
        tick("t1_rst0", 0, 0, 0);
        tick("t1_rst1", 0, 0, 0);
        rst = 1'b0;
        id_set(1, 5, 1, 0, 0, 0, 0, 0);
        tick("t1_clean", 1, 0, 0);
        drain_all("t1_drain");

        // RAW on r5: stalls until one cycle after r5 retires.
        id_set(1, 0, 0, 0, 0, 5, 1, 0);
        tick("t2_wr", 1, 0);
        id_set(1, 5, 1, 0, 0, 6, 1, 0);
        tick("t2_stall_a", 0, 1);
        tick("t2_stall_b", 0, 1);
        wb_front();
        tick("t2_wb_cycle", 0, 1);
        wb_none();
        tick("t2_after_wb", 1, 0);
        drain_all("t2_drain");

        // r0 never becomes busy.
        id_set(1, 0, 0, 0, 0, 0, 1, 0);
        tick("t3_wr0", 1, 0);
        id_set(1, 0, 1, 0, 1, 0, 1, 0);
        tick("t3_rd0", 1, 0);
        drain_all("t3_drain");

        // In-flight bound.
        for (int i = 1; i <= 4; i++) begin
            id_set(1, 0, 0, 0, 0, i, 1, 0);
            tick("t4_fill", 1, 0);
        end
        id_set(1, 0, 0, 0, 0, 8, 1, 0);
        tick("t4_full", 0, 1);
        wb_front();
        tick("t4_full_wb", 0, 1);
        wb_none();
        tick("t4_after_wb", 1, 0);
        id_set(0, 0, 0, 0, 0, 0, 0, 0);
        wb_front();
        tick("t4_retire");
        id_set(1, 0, 0, 0, 0, 10, 1, 0);
        wb_front();
        tick("t4_issue_and_wb", 1, 0);
        wb_none();
        id_set(1, 0, 0, 0, 0, 11, 1, 0);
        tick("t4_refill", 1, 0);
        id_set(1, 0, 0, 0, 0, 12, 1, 0);
        tick("t4_full_again", 0, 1);
        drain_all("t4_drain");

        // Serial instruction waits for empty pipeline, then drains.
        id_set(1, 0, 0, 0, 0, 1, 1, 0);
        tick("t5_a", 1, 0);
        id_set(1, 0, 0, 0, 0, 2, 1, 0);
        tick("t5_b", 1, 0);
        id_set(1, 0, 0, 0, 0, 0, 0, 1);
        tick("t5_fence_wait", 0, 1, 1);
        wb_front();
        tick("t5_wb1", 0, 1, 1);
        wb_front();
        tick("t5_wb2", 0, 1, 1);
        wb_none();
        tick("t5_fence_issue", 1, 0, 0);
        id_set(1, 0, 0, 0, 0, 3, 1, 0);
        tick("t5_drain_stall", 0, 1, 1);
        br = 1'b1;
        tick("t5_drain_flush", 0, 0, 1);
        br = 1'b0;
        wb_front();
        tick("t5_fence_wb", 0, 1, 1);
        wb_none();
        tick("t5_next", 1, 0, 0);
        drain_all("t5_drain");

        // Taken branch flushes without touching the scoreboard.
        id_set(1, 0, 0, 0, 0, 3, 1, 0);
        tick("t6_wr3", 1, 0);
        id_set(1, 4, 1, 0, 0, 0, 0, 0);
        br = 1'b1;
        tick("t6_flush", 0, 0);
        br = 1'b0;
        id_set(1, 3, 1, 0, 0, 0, 0, 0);
        tick("t6_still_busy", 0, 1);
        drain_all("t6_drain");
        // Same-cycle clear and set of r7: set wins.
        wbv = 1'b1; wbrd = 5'd7; wbwe = 1'b1;
        id_set(1, 0, 0, 0, 0, 7, 1, 0);
        tick("t6_setclr", 1, 0);
        wb_none();
        id_set(1, 7, 1, 0, 0, 0, 0, 0);
        tick("t6_r7_busy", 0, 1);
        drain_all("t6_drain2");
        id_set(1, 7, 1, 0, 0, 0, 0, 0);
        tick("t6_r7_free", 1, 0);
        drain_all("t6_drain3");

        // Random traffic, including resets mid-operation and flushes in DRAIN.
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            id_set($urandom_range(0, 3) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 1) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 1) != 0,
                   $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 19) == 0);
            ld = $urandom_range(0, 1) != 0;
            br = ($urandom_range(0, 9) == 0);
            if (q.size() != 0 && $urandom_range(0, 99) < 40) begin
                wb_front();
            end else if (q.size() == 0 && $urandom_range(0, 99) < 10) begin
                wbv = 1'b1; wbrd = 5'($urandom_range(0, 31)); wbwe = 1'b1;
            end else begin
                wb_none();
            end
            tick("rand");
        end
        rst = 1'b0;
        drain_all("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
